// File: rtl/mult_mem_ctrl.sv
// Controller that owns the RAM: reads two operands, multiplies them with a shift-add datapath,
// and writes the 16-bit product back as low byte at adr_r and high byte at adr_r+1.
module mult_mem_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADR_W  = 3
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [ADR_W-1:0]    adr_a_i,
  input  logic [ADR_W-1:0]    adr_b_i,
  input  logic [ADR_W-1:0]    adr_r_i,
  input  logic [DATA_W-1:0]   ram_dout_i,
  output logic                ram_w_o,
  output logic [ADR_W-1:0]    ram_adr_o,
  output logic [DATA_W-1:0]   ram_din_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [2*DATA_W-1:0] product_o
);

  localparam int unsigned PW   = 2 * DATA_W;
  localparam int unsigned CntW = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

  typedef enum logic [2:0] {
    StIdle, StRdA, StRdB, StWaitB, StMul, StWrLo, StWrHi, StDone
  } state_e;

  state_e            state_q, state_d;
  logic [ADR_W-1:0]  adr_a_q, adr_a_d;
  logic [ADR_W-1:0]  adr_b_q, adr_b_d;
  logic [ADR_W-1:0]  adr_r_q, adr_r_d;
  logic [PW-1:0]     p_q, p_d;
  logic [PW-1:0]     m_q, m_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]     product_q, product_d;
  logic [PW-1:0]     p_add;

  assign p_add = p_q + (q_q[0] ? m_q : '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      adr_a_q   <= '0;
      adr_b_q   <= '0;
      adr_r_q   <= '0;
      p_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      adr_a_q   <= adr_a_d;
      adr_b_q   <= adr_b_d;
      adr_r_q   <= adr_r_d;
      p_q       <= p_d;
      m_q       <= m_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    adr_a_d   = adr_a_q;
    adr_b_d   = adr_b_q;
    adr_r_d   = adr_r_q;
    p_d       = p_q;
    m_d       = m_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          adr_a_d = adr_a_i;
          adr_b_d = adr_b_i;
          adr_r_d = adr_r_i;
          state_d = StRdA;
        end
      end
      StRdA: state_d = StRdB;
      StRdB: begin
        // Operand A goes straight into the multiplicand register.
        m_d     = {{DATA_W{1'b0}}, ram_dout_i};
        state_d = StWaitB;
      end
      StWaitB: begin
        q_d     = ram_dout_i;
        p_d     = '0;
        cnt_d   = '0;
        state_d = StMul;
      end
      StMul: begin
        p_d   = p_add;
        m_d   = m_q << 1;
        q_d   = q_q >> 1;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          product_d = p_add;
          state_d   = StWrLo;
        end
      end
      StWrLo:  state_d = StWrHi;
      StWrHi:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ram_w_o   = 1'b0;
    ram_adr_o = '0;
    ram_din_o = '0;
    busy_o    = (state_q != StIdle);
    done_o    = (state_q == StDone);
    case (state_q)
      StRdA:          ram_adr_o = adr_a_q;
      StRdB, StWaitB: ram_adr_o = adr_b_q;
      StWrLo: begin
        ram_w_o   = 1'b1;
        ram_adr_o = adr_r_q;
        ram_din_o = product_q[DATA_W-1:0];
      end
      StWrHi: begin
        ram_w_o   = 1'b1;
        ram_adr_o = adr_r_q + ADR_W'(1);
        ram_din_o = product_q[PW-1:DATA_W];
      end
      default: ;
    endcase
  end

  assign product_o = product_q;

endmodule

// File: tb/tb_mult_mem_ctrl.sv
// Scoreboard bench for mult_mem_ctrl with a behavioural 8x8 RAM (registered read port).
module tb_mult_mem_ctrl;

  logic        clk;
  logic        rst_ni;
  logic        start;
  logic [2:0]  adr_a, adr_b, adr_r;
  logic [7:0]  ram_dout;
  logic        ram_w;
  logic [2:0]  ram_adr;
  logic [7:0]  ram_din;
  logic        busy, done;
  logic [15:0] product;

  logic        tb_we;
  logic [2:0]  tb_adr;
  logic [7:0]  tb_din;
  logic [7:0]  mem [8];
  int          edge_n;

  typedef struct {
    logic [15:0] prod;
    logic [2:0]  r;
    int          start_edge;
  } exp_t;
  exp_t sb[$];

  int checks;
  int failures;

  mult_mem_ctrl #(.DATA_W(8), .ADR_W(3)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .start_i    (start),
    .adr_a_i    (adr_a),
    .adr_b_i    (adr_b),
    .adr_r_i    (adr_r),
    .ram_dout_i (ram_dout),
    .ram_w_o    (ram_w),
    .ram_adr_o  (ram_adr),
    .ram_din_o  (ram_din),
    .busy_o     (busy),
    .done_o     (done),
    .product_o  (product)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bench-side preload port shares the RAM; it is only used while the DUT is idle.
  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (tb_we) mem[tb_adr] <= tb_din;
    else if (ram_w) mem[ram_adr] <= ram_din;
    else ram_dout <= mem[ram_adr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Monitor: every done pulse must match the oldest outstanding operation.
  initial begin
    exp_t e;
    logic [2:0] r_hi;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          e = sb.pop_front();
          r_hi = e.r + 3'd1;
          check("product", 32'(product), 32'(e.prod));
          check("mem_lo", 32'(mem[e.r]), 32'(e.prod[7:0]));
          check("mem_hi", 32'(mem[r_hi]), 32'(e.prod[15:8]));
          check("done_latency", 32'(edge_n - e.start_edge), 32'd13);
        end
      end
    end
  end

  task automatic preload(input logic [2:0] a, input logic [7:0] v);
    @(negedge clk);
    tb_we  = 1'b1;
    tb_adr = a;
    tb_din = v;
    @(negedge clk);
    tb_we  = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] a, input logic [2:0] b, input logic [2:0] r,
                        input logic [15:0] exp, input bit hold);
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1;
    adr_a = a;
    adr_b = b;
    adr_r = r;
    @(posedge clk);
    @(negedge clk);
    sb.push_back('{exp, r, edge_n});
    check("busy_after_start", 32'(busy), 32'd1);
    if (!hold) start = 1'b0;
    // Scramble the address inputs; the latched copies must be used.
    adr_a = ~a;
    adr_b = ~b;
    adr_r = r + 3'd3;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) fail_now("done_timeout");
    start = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    edge_n   = 0;
    rst_ni   = 1'b0;
    start    = 1'b0;
    adr_a    = '0;
    adr_b    = '0;
    adr_r    = '0;
    tb_we    = 1'b0;
    tb_adr   = '0;
    tb_din   = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ram_w", 32'(ram_w), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    check("rst_ram_adr", 32'(ram_adr), 32'd0);
    rst_ni = 1'b1;

    // 13 x 11 = 0x008F
    preload(3'd1, 8'd13);
    preload(3'd2, 8'd11);
    run_op(3'd1, 3'd2, 3'd4, 16'h008F, 1'b0);

    // 255 x 255 = 0xFE01, high byte wraps to address 0
    preload(3'd0, 8'd255);
    preload(3'd6, 8'd255);
    run_op(3'd0, 3'd6, 3'd7, 16'hFE01, 1'b0);

    // Square with result overwriting the operand; start held high throughout
    preload(3'd3, 8'd16);
    run_op(3'd3, 3'd3, 3'd3, 16'h0100, 1'b1);
    @(negedge clk);
    check("single_op_idle1", 32'(busy), 32'd0);
    @(negedge clk);
    check("single_op_idle2", 32'(busy), 32'd0);

    // Zero operand keeps full latency; back-to-back start one cycle after DONE
    preload(3'd1, 8'd0);
    preload(3'd2, 8'd200);
    run_op(3'd1, 3'd2, 3'd6, 16'h0000, 1'b0);
    run_op(3'd2, 3'd0, 3'd5, 16'hC670, 1'b0);  // 200 x 254

    // Reset during MUL aborts without writing
    @(negedge clk);
    preload(3'd4, 8'h5A);
    preload(3'd1, 8'd13);
    preload(3'd2, 8'd11);
    start = 1'b1;
    adr_a = 3'd1;
    adr_b = 3'd2;
    adr_r = 3'd4;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst_ni = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ram_w", 32'(ram_w), 32'd0);
    check("abort_product", 32'(product), 32'd0);
    rst_ni = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_mem_lo", 32'(mem[4]), 32'h5A);
    check("abort_mem_hi", 32'(mem[5]), 32'h70);
    check("pending_ops", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
